mult_arb_ctrl: RTL and testbench

Round-robin controller that shares one `multiply8` 8x8 multiplier core among up to `NREQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the core's operand inputs. It holds those operands stable for the core's pipeline window, samples the 16-bit product and returns it with the requester's ID over a valid/ready response channel. It sits between client blocks and the core, and is the only block allowed to drive the core's `a`/`b` inputs.

---
 rtl/mult_arb_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mult_arb_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arb_ctrl.sv
// Round-robin arbiter that time-shares one 8x8 multiply8 core among NREQ requesters.
// Optional build macro: MULT_ARB_ZERO_SKIP_EN (zero operand bypasses the core).
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting for a request; grants the round-robin winner
//   ST_HOLD | operands held on mul_a/mul_b, counting down the core window
//   ST_RESP | product registered; rsp_valid high until rsp_ready
module mult_arb_ctrl #(
    parameter int NREQ = 4,
    parameter int HOLD = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          mul_a,
    output logic [7:0]          mul_b,
    input  logic [15:0]         mul_c,
    output logic                rsp_valid,
    output logic [2:0]          rsp_id,
    output logic [15:0]         rsp_data,
    input  logic                rsp_ready,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_op_a;
    logic [7:0]  r_op_b;
    logic [2:0]  r_op_id;
    logic [2:0]  r_last_grant;
    logic [3:0]  r_cnt;
    logic [15:0] r_rsp_data;
    logic [2:0]  r_rsp_id;

    logic        w_any;
    logic [2:0]  w_win_idx;
    logic [3:0]  w_rr_sum;
    logic [7:0]  w_win_a;
    logic [7:0]  w_win_b;
    logic        w_zero_skip;

    // Search starts one past the last grant so every requester is reached within NREQ grants.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = 3'd0;
        w_rr_sum  = 4'd0;
        for (int k = 1; k <= NREQ; k++) begin
            w_rr_sum = {1'b0, r_last_grant} + 4'(k);
            if (w_rr_sum >= 4'(NREQ))
                w_rr_sum = w_rr_sum - 4'(NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (!w_any && (w_rr_sum == 4'(i)) && req_valid[i]) begin
                    w_any     = 1'b1;
                    w_win_idx = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_win_a = 8'd0;
        w_win_b = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_idx == 3'(i)) begin
                w_win_a = req_a[8*i +: 8];
                w_win_b = req_b[8*i +: 8];
            end
        end
    end

`ifdef MULT_ARB_ZERO_SKIP_EN
    assign w_zero_skip = w_any && ((w_win_a == 8'd0) || (w_win_b == 8'd0));
`else
    assign w_zero_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any)
                    w_state_nxt = w_zero_skip ? ST_RESP : ST_HOLD;
            end
            ST_HOLD: begin
                if (r_cnt == 4'd0)
                    w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // req_ready is masked by rst_n so nothing is accepted while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == ST_IDLE) && w_any) begin
            for (int i = 0; i < NREQ; i++)
                req_ready[i] = (w_win_idx == 3'(i));
        end
        busy      = (r_state != ST_IDLE);
        rsp_valid = (r_state == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_a       <= 8'd0;
            r_op_b       <= 8'd0;
            r_op_id      <= 3'd0;
            r_last_grant <= 3'(NREQ-1);
            r_cnt        <= 4'd0;
            r_rsp_data   <= 16'd0;
            r_rsp_id     <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_last_grant <= w_win_idx;
                        r_op_id      <= w_win_idx;
                        if (w_zero_skip) begin
                            r_rsp_data <= 16'd0;
                            r_rsp_id   <= w_win_idx;
                        end else begin
                            r_op_a <= w_win_a;
                            r_op_b <= w_win_b;
                            r_cnt  <= 4'(HOLD-1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_data <= mul_c;
                        r_rsp_id   <= r_op_id;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_a    = r_op_a;
    assign mul_b    = r_op_b;
    assign rsp_data = r_rsp_data;
    assign rsp_id   = r_rsp_id;

endmodule

// File: tb/tb_mult_arb_ctrl.sv
// Scoreboard bench for mult_arb_ctrl with a behavioural multiply8 core model.
// Honours MULT_ARB_ZERO_SKIP_EN for the zero-operand latency expectations.
module tb_mult_arb_ctrl;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [15:0]       mul_c;
    logic              rsp_valid;
    logic [2:0]        rsp_id;
    logic [15:0]       rsp_data;
    logic              rsp_ready;
    logic              busy;

    always #5 clk = ~clk;

    mult_arb_ctrl #(.NREQ(NREQ), .HOLD(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    // Core model: low nibble combinational, upper 12 bits one register stage late.
    logic [15:0] w_prod;
    logic [11:0] r_core_hi = 12'd0;
    assign w_prod = 16'(mul_a) * 16'(mul_b);
    always @(posedge clk) r_core_hi <= w_prod[15:4];
    assign mul_c = {r_core_hi, w_prod[3:0]};

    typedef struct {
        logic [2:0]  id;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   g_id[$];
    int   g_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                exp_q.push_back('{id: 3'(i), data: 16'(req_a[8*i +: 8]) * 16'(req_b[8*i +: 8])});
                g_id.push_back(i);
                g_cyc.push_back(cyc);
            end
        end
    end

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_valid[i]    = 1'b1;
    endtask

    task automatic wait_rsp_single(output int n);
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req_valid = '0;
            if (rsp_valid === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int   n;
        exp_t e;
        rst_n = 1'b0; req_valid = '1; req_a = '1; req_b = '1; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        n_checks++;
        if ({rsp_valid, busy, mul_a, mul_b, rsp_data, rsp_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b busy=%b a=%0d b=%0d d=%0d id=%0d exp all 0",
                     rsp_valid, busy, mul_a, mul_b, rsp_data, rsp_id);
        end
        req_valid = '0;
        set_req(2, 8'd11, 8'd13);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL first_grant_req2 got=%b exp=0100", req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_in_hold got=%b exp=1", busy);
        end
        rst_n = 1'b0; req_valid = '1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL ready_gated_in_reset got=%b exp=0000", req_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy, mul_a, mul_b, rsp_data, rsp_id} !== '0) begin
            n_fail++;
            $display("FAIL midop_reset_outputs got v=%b busy=%b a=%0d b=%0d d=%0d id=%0d exp all 0",
                     rsp_valid, busy, mul_a, mul_b, rsp_data, rsp_id);
        end
        exp_q.delete();
        req_valid = '0;
        set_req(0, 8'd3, 8'd5);
        set_req(3, 8'd40, 8'd2);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL post_reset_grant got=%b exp=0001", req_ready);
        end
        wait_rsp_single(n);
        n_checks++;
        if (n != 3) begin
            n_fail++; $display("FAIL post_reset_latency got=%0d exp=3", n);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL post_reset_rsp got=no_expectation exp=id0");
        end else begin
            e = exp_q.pop_front();
            if (rsp_id !== e.id || rsp_data !== e.data || e.id !== 3'd0) begin
                n_fail++;
                $display("FAIL post_reset_rsp got id=%0d d=%0d exp id=0 d=%0d", rsp_id, rsp_data, e.data);
            end
        end
    endtask

    task automatic test_basic();
        exp_t e;
        @(negedge clk);
        set_req(0, 8'd200, 8'd150);
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL basic_grant got=%b exp=0001", req_ready);
        end
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            req_valid = '0;
            n_checks++;
            if (mul_a !== 8'd200 || mul_b !== 8'd150 || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_hold_T%0d got a=%0d b=%0d v=%b exp a=200 b=150 v=0", k, mul_a, mul_b, rsp_valid);
            end
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'd30000 || rsp_id !== 3'd0) begin
            n_fail++;
            $display("FAIL basic_rsp got v=%b d=%0d id=%0d exp v=1 d=30000 id=0", rsp_valid, rsp_data, rsp_id);
        end
        if (exp_q.size() != 0) e = exp_q.pop_front();
    endtask

    task automatic test_nibble();
        int   ids[2]  = '{1, 3};
        int   av[2]   = '{16, 255};
        int   res[2]  = '{256, 65025};
        int   n;
        exp_t e;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            set_req(ids[t], 8'(av[t]), 8'(av[t]));
            wait_rsp_single(n);
            n_checks++;
            if (n != 3 || rsp_data !== 16'(res[t]) || rsp_id !== 3'(ids[t])) begin
                n_fail++;
                $display("FAIL nibble_%0d got lat=%0d d=%0d id=%0d exp lat=3 d=%0d id=%0d",
                         t, n, rsp_data, rsp_id, res[t], ids[t]);
            end
            if (exp_q.size() != 0) e = exp_q.pop_front();
        end
    endtask

    task automatic test_round_robin();
        int   nrsp = 0;
        exp_t e;
        int   exp_order[5] = '{0, 1, 2, 3, 0};
        g_id.delete(); g_cyc.delete();
        @(negedge clk);
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i*37 + 5), 8'(250 - i*11));
        for (int k = 0; k < 60 && nrsp < 5; k++) begin
            @(negedge clk);
            if (g_id.size() >= 5) req_valid = '0;
            if (rsp_valid === 1'b1) begin
                nrsp++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rr_rsp got=unexpected id=%0d exp=none", rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_id !== e.id || rsp_data !== e.data) begin
                        n_fail++;
                        $display("FAIL rr_rsp got id=%0d d=%0d exp id=%0d d=%0d", rsp_id, rsp_data, e.id, e.data);
                    end
                end
            end
        end
        req_valid = '0;
        n_checks++;
        if (nrsp != 5 || g_id.size() != 5) begin
            n_fail++; $display("FAIL rr_count got rsp=%0d grants=%0d exp 5/5", nrsp, g_id.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (g_id[k] != exp_order[k]) begin
                    n_fail++; $display("FAIL rr_order_%0d got=%0d exp=%0d", k, g_id[k], exp_order[k]);
                end
            end
            for (int k = 1; k < 5; k++) begin
                n_checks++;
                if (g_cyc[k] - g_cyc[k-1] != 4) begin
                    n_fail++; $display("FAIL rr_interval_%0d got=%0d exp=4", k, g_cyc[k] - g_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int   n = -1;
        exp_t e;
        e.id = 3'd1; e.data = 16'd408;
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(0, 8'd7, 8'd9);
        set_req(1, 8'd12, 8'd34);
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_grant got=%b exp=0010", req_ready);
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            req_valid[1] = 1'b0;
            if (rsp_valid === 1'b1) begin n = k; break; end
        end
        n_checks++;
        if (n != 3) begin
            n_fail++; $display("FAIL bp_latency got=%0d exp=3", n);
        end
        if (exp_q.size() != 0) e = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_data !== 16'd408 || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_stall_%0d got v=%b id=%0d d=%0d rdy=%b exp v=1 id=1 d=408 rdy=0000",
                         k, rsp_valid, rsp_id, rsp_data, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_next_grant got rdy=%b v=%b exp rdy=0001 v=0", req_ready, rsp_valid);
        end
        wait_rsp_single(n);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL bp_second_rsp got=no_expectation exp=id0");
        end else begin
            e = exp_q.pop_front();
            if (n != 3 || rsp_id !== e.id || rsp_data !== e.data) begin
                n_fail++;
                $display("FAIL bp_second_rsp got lat=%0d id=%0d d=%0d exp lat=3 id=%0d d=%0d",
                         n, rsp_id, rsp_data, e.id, e.data);
            end
        end
    endtask

    task automatic test_zero();
        int   n;
        exp_t e;
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(1, 8'd0, 8'd77);
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL zero_grant got=%b exp=0010", req_ready);
        end
        wait_rsp_single(n);
`ifdef MULT_ARB_ZERO_SKIP_EN
        n_checks++;
        if (n != 1 || mul_a !== 8'd7 || mul_b !== 8'd9) begin
            n_fail++; $display("FAIL zero_skip got lat=%0d a=%0d b=%0d exp lat=1 a=7 b=9", n, mul_a, mul_b);
        end
`else
        n_checks++;
        if (n != 3 || mul_a !== 8'd0 || mul_b !== 8'd77) begin
            n_fail++; $display("FAIL zero_normal got lat=%0d a=%0d b=%0d exp lat=3 a=0 b=77", n, mul_a, mul_b);
        end
`endif
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL zero_rsp got=no_expectation exp=id1");
        end else begin
            e = exp_q.pop_front();
            if (rsp_id !== e.id || rsp_data !== e.data || rsp_data !== 16'd0) begin
                n_fail++;
                $display("FAIL zero_rsp got id=%0d d=%0d exp id=%0d d=0", rsp_id, rsp_data, e.id);
            end
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL final_drain got pending=%0d busy=%b exp 0/0", exp_q.size(), busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_nibble();
        test_round_robin();
        test_backpressure();
        test_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
